// File: rtl/xibus_target.sv
// XiBus target: decodes a multiplexed address cycle, runs one request/acknowledge
// transaction on the local register bus and terminates the bus cycle with ready.
module xibus_target #(
    parameter logic [31:0] BASE    = 32'h0000_0000,
    parameter logic [31:0] MASK    = 32'hFFFF_0000,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        mst_adrcyn,
    input  logic [31:0] bus_ad_i,
    input  logic        bus_tm1n,
    input  logic        bus_tm0n,
    output logic [31:0] slv_ad_o,
    output logic        slv_ad_oe,
    output logic        slv_rdy_o,
    output logic        slv_err_o,
    output logic        loc_req,
    output logic        loc_we,
    output logic [3:0]  loc_be,
    output logic [31:0] loc_addr,
    output logic [31:0] loc_wdata,
    input  logic        loc_ack,
    input  logic [31:0] loc_rdata
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, WDATA, REQ, RESP} state_t;

    state_t        state;
    logic [CW-1:0] cnt;

    logic       dec_hit;
    logic       dec_legal;
    logic       dec_we;
    logic [3:0] dec_be;

    // Transfer-mode / lane-code decode of the current address cycle
    always_comb begin
        dec_hit   = ((bus_ad_i & MASK) == BASE);
        dec_legal = 1'b0;
        dec_we    = 1'b0;
        dec_be    = 4'b0000;
        case ({bus_tm1n, bus_tm0n})
            2'b11: begin
                dec_legal = (bus_ad_i[1:0] == 2'b00);
                dec_be    = 4'b1111;
            end
            2'b00: begin
                dec_legal = 1'b1;
                dec_we    = 1'b1;
                dec_be    = 4'(4'b0001 << bus_ad_i[1:0]);
            end
            2'b01: begin
                dec_we = 1'b1;
                case (bus_ad_i[1:0])
                    2'b00:   begin dec_legal = 1'b1; dec_be = 4'b1111; end
                    2'b01:   begin dec_legal = 1'b1; dec_be = 4'b0011; end
                    2'b11:   begin dec_legal = 1'b1; dec_be = 4'b1100; end
                    default: begin dec_legal = 1'b0; dec_be = 4'b0000; end
                endcase
            end
            default: begin
                dec_legal = 1'b0;
                dec_we    = 1'b0;
                dec_be    = 4'b0000;
            end
        endcase
    end

    // Bus-cycle FSM with all outputs registered
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= IDLE;
            cnt       <= '0;
            slv_ad_o  <= '0;
            slv_ad_oe <= 1'b0;
            slv_rdy_o <= 1'b0;
            slv_err_o <= 1'b0;
            loc_req   <= 1'b0;
            loc_we    <= 1'b0;
            loc_be    <= '0;
            loc_addr  <= '0;
            loc_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!mst_adrcyn && dec_hit) begin
                        if (!dec_legal) begin
                            slv_rdy_o <= 1'b1;
                            slv_err_o <= 1'b1;
                            slv_ad_oe <= 1'b0;
                            state     <= RESP;
                        end else begin
                            loc_addr <= {bus_ad_i[31:2], 2'b00};
                            loc_be   <= dec_be;
                            loc_we   <= dec_we;
                            if (dec_we) begin
                                state <= WDATA;
                            end else begin
                                loc_req <= 1'b1;
                                cnt     <= '0;
                                state   <= REQ;
                            end
                        end
                    end
                end
                WDATA: begin
                    loc_wdata <= bus_ad_i;
                    loc_we    <= 1'b1;
                    loc_req   <= 1'b1;
                    cnt       <= '0;
                    state     <= REQ;
                end
                REQ: begin
                    // Acknowledge takes priority over a timeout on the same edge
                    if (loc_ack) begin
                        loc_req   <= 1'b0;
                        if (!loc_we) begin
                            slv_ad_o <= loc_rdata;
                        end
                        slv_rdy_o <= 1'b1;
                        slv_err_o <= 1'b0;
                        slv_ad_oe <= !loc_we;
                        state     <= RESP;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        loc_req   <= 1'b0;
                        slv_rdy_o <= 1'b1;
                        slv_err_o <= 1'b1;
                        slv_ad_oe <= 1'b0;
                        state     <= RESP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RESP: begin
                    slv_rdy_o <= 1'b0;
                    slv_err_o <= 1'b0;
                    slv_ad_oe <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_xibus_target.sv
// Bench for xibus_target: directed plan items plus randomized transactions
// checked against a transaction-level reference model.
module tb_xibus_target;

    localparam int unsigned  TIMEOUT = 16;
    localparam logic [31:0]  BASE    = 32'h0000_0000;
    localparam logic [31:0]  MASK    = 32'hFFFF_0000;

    logic        clk;
    logic        rstn;
    logic        mst_adrcyn;
    logic [31:0] bus_ad_i;
    logic        bus_tm1n;
    logic        bus_tm0n;
    logic [31:0] slv_ad_o;
    logic        slv_ad_oe;
    logic        slv_rdy_o;
    logic        slv_err_o;
    logic        loc_req;
    logic        loc_we;
    logic [3:0]  loc_be;
    logic [31:0] loc_addr;
    logic [31:0] loc_wdata;
    logic        loc_ack;
    logic [31:0] loc_rdata;

    int checks = 0;
    int errors = 0;

    xibus_target #(.BASE(BASE), .MASK(MASK), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rstn(rstn), .mst_adrcyn(mst_adrcyn), .bus_ad_i(bus_ad_i),
        .bus_tm1n(bus_tm1n), .bus_tm0n(bus_tm0n), .slv_ad_o(slv_ad_o),
        .slv_ad_oe(slv_ad_oe), .slv_rdy_o(slv_rdy_o), .slv_err_o(slv_err_o),
        .loc_req(loc_req), .loc_we(loc_we), .loc_be(loc_be), .loc_addr(loc_addr),
        .loc_wdata(loc_wdata), .loc_ack(loc_ack), .loc_rdata(loc_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Lane table for {tm1n,tm0n} and the AD lane code
    function automatic void ref_decode(input logic [1:0] tm, input logic [1:0] ad,
                                       output bit legal, output bit we, output logic [3:0] be);
        logic [3:0] single_tbl [4];
        logic [3:0] multi_tbl  [4];
        single_tbl = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        multi_tbl  = '{4'b1111, 4'b0011, 4'b0000, 4'b1100};
        legal = 1'b0;
        we    = 1'b0;
        be    = 4'b0000;
        if (tm == 2'b11) begin
            legal = (ad == 2'b00);
            be    = 4'b1111;
        end else if (tm == 2'b00) begin
            legal = 1'b1;
            we    = 1'b1;
            be    = single_tbl[ad];
        end else if (tm == 2'b01) begin
            we    = 1'b1;
            legal = (ad != 2'b10);
            be    = multi_tbl[ad];
        end
    endfunction

    // One complete bus transaction; d = ack delay in request cycles (d >= TIMEOUT: never acked)
    task automatic run_txn(input logic [31:0] addr, input logic [1:0] tm, input logic [1:0] ad,
                           input logic [31:0] wdata, input int d, input logic [31:0] rdata,
                           input bit pulse);
        bit hit, legal, we, tout;
        logic [3:0] be;
        hit  = (({addr[31:2], ad} & MASK) == BASE);
        tout = (d >= int'(TIMEOUT));
        ref_decode(tm, ad, legal, we, be);
        mst_adrcyn = 1'b0;
        bus_ad_i   = {addr[31:2], ad};
        {bus_tm1n, bus_tm0n} = tm;
        @(posedge clk); #1;
        mst_adrcyn = 1'b1;
        bus_ad_i   = wdata;
        {bus_tm1n, bus_tm0n} = 2'b11;
        if (!hit) begin
            repeat (3) begin
                @(negedge clk);
                chk("miss_req", 32'(loc_req), 32'd0);
                chk("miss_rdy", 32'(slv_rdy_o), 32'd0);
            end
            return;
        end
        if (!legal) begin
            @(negedge clk);
            chk("ill_rdy", 32'(slv_rdy_o), 32'd1);
            chk("ill_err", 32'(slv_err_o), 32'd1);
            chk("ill_req", 32'(loc_req), 32'd0);
            chk("ill_oe", 32'(slv_ad_oe), 32'd0);
        end else begin
            if (we) begin
                @(negedge clk);
                chk("wdata_cyc_req", 32'(loc_req), 32'd0);
                @(posedge clk); #1;
                bus_ad_i = $urandom;
            end
            for (int k = 0; k < int'(TIMEOUT); k++) begin
                @(negedge clk);
                chk("req_high", 32'(loc_req), 32'd1);
                chk("req_addr", loc_addr, {addr[31:2], 2'b00});
                chk("req_be", 32'(loc_be), 32'(be));
                chk("req_we", 32'(loc_we), 32'(we));
                if (we) chk("req_wdata", loc_wdata, wdata);
                if (pulse && k == 1) begin
                    mst_adrcyn = 1'b0;
                    bus_ad_i   = {addr[31:2], 2'b00};
                end
                if (k == d) begin
                    loc_ack   = 1'b1;
                    loc_rdata = rdata;
                end
                @(posedge clk); #1;
                loc_ack    = 1'b0;
                loc_rdata  = $urandom;
                mst_adrcyn = 1'b1;
                if (k == d) break;
            end
            @(negedge clk);
            chk("resp_req", 32'(loc_req), 32'd0);
            chk("resp_rdy", 32'(slv_rdy_o), 32'd1);
            chk("resp_err", 32'(slv_err_o), 32'(tout));
            chk("resp_oe", 32'(slv_ad_oe), 32'(!we && !tout));
            if (!we && !tout) chk("resp_rdata", slv_ad_o, rdata);
        end
        @(negedge clk);
        chk("post_rdy", 32'(slv_rdy_o), 32'd0);
        chk("post_err", 32'(slv_err_o), 32'd0);
        chk("post_oe", 32'(slv_ad_oe), 32'd0);
        chk("post_req", 32'(loc_req), 32'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ad"}, slv_ad_o, 32'd0);
        chk({tag, "_oe"}, 32'(slv_ad_oe), 32'd0);
        chk({tag, "_rdy"}, 32'(slv_rdy_o), 32'd0);
        chk({tag, "_err"}, 32'(slv_err_o), 32'd0);
        chk({tag, "_req"}, 32'(loc_req), 32'd0);
        chk({tag, "_we"}, 32'(loc_we), 32'd0);
        chk({tag, "_be"}, 32'(loc_be), 32'd0);
        chk({tag, "_addr"}, loc_addr, 32'd0);
        chk({tag, "_wdata"}, loc_wdata, 32'd0);
    endtask

    initial begin
        logic [31:0] a;
        logic [1:0]  tm;
        int          d;
        rstn = 1'b0; mst_adrcyn = 1'b1; bus_ad_i = '0;
        bus_tm1n = 1'b1; bus_tm0n = 1'b1; loc_ack = 1'b0; loc_rdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        rstn = 1'b1;

        // Read hit, ack on third request cycle
        run_txn(32'h0000_1230, 2'b11, 2'b00, 32'h0, 2, 32'hDEAD_BEEF, 1'b0);
        // Single-byte and multi-byte writes
        for (int i = 0; i < 4; i++)
            run_txn(32'h0000_2000, 2'b00, 2'(i), 32'hA5A5_A5A5, 1, 32'h0, 1'b0);
        run_txn(32'h0000_2004, 2'b01, 2'b00, 32'hA5A5_A5A5, 0, 32'h0, 1'b0);
        run_txn(32'h0000_2008, 2'b01, 2'b01, 32'hA5A5_A5A5, 3, 32'h0, 1'b0);
        run_txn(32'h0000_200C, 2'b01, 2'b11, 32'hA5A5_A5A5, 2, 32'h0, 1'b0);
        // Illegal encodings
        run_txn(32'h0000_3000, 2'b10, 2'b00, 32'h0, 0, 32'h0, 1'b0);
        run_txn(32'h0000_3000, 2'b01, 2'b10, 32'h0, 0, 32'h0, 1'b0);
        run_txn(32'h0000_3000, 2'b11, 2'b01, 32'h0, 0, 32'h0, 1'b0);
        // Timeout, then ack exactly on the last allowed cycle
        run_txn(32'h0000_4000, 2'b11, 2'b00, 32'h0, int'(TIMEOUT), 32'h1111_2222, 1'b0);
        run_txn(32'h0000_4000, 2'b11, 2'b00, 32'h0, int'(TIMEOUT) - 1, 32'h3333_4444, 1'b0);
        // Miss, then a stray address cycle while busy
        run_txn(32'h0001_0000, 2'b11, 2'b00, 32'h0, 0, 32'h0, 1'b0);
        run_txn(32'h0000_5000, 2'b11, 2'b00, 32'h0, 4, 32'h5555_AAAA, 1'b1);
        // Stray ack while idle must not terminate anything
        loc_ack = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("idle_ack_rdy", 32'(slv_rdy_o), 32'd0);
            chk("idle_ack_req", 32'(loc_req), 32'd0);
        end
        loc_ack = 1'b0;

        // Reset while in REQ aborts silently
        mst_adrcyn = 1'b0; bus_ad_i = 32'h0000_6000; {bus_tm1n, bus_tm0n} = 2'b11;
        @(posedge clk); #1;
        mst_adrcyn = 1'b1;
        @(negedge clk);
        chk("pre_rst_req", 32'(loc_req), 32'd1);
        rstn = 1'b0;
        @(negedge clk);
        chk_all_zero("mid_rst");
        rstn = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("after_rst_rdy", 32'(slv_rdy_o), 32'd0);
            chk("after_rst_req", 32'(loc_req), 32'd0);
        end
        run_txn(32'h0000_7770, 2'b11, 2'b00, 32'h0, 1, 32'hCAFE_F00D, 1'b0);

        // Randomized transactions
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 4) == 0) a = {16'($urandom_range(1, 16'hFFFF)), 16'($urandom)};
            else a = {16'h0000, 16'($urandom)};
            tm = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) d = $urandom_range(int'(TIMEOUT) - 2, int'(TIMEOUT) + 2);
            else d = $urandom_range(0, 5);
            run_txn(a, tm, 2'($urandom), $urandom, d, $urandom, 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/xibus_target.md
Name: xibus_target

Overview:
- Target-side (slave) end of the multiplexed XiBus address/data interface.
- Decodes the CPU address cycle: `mst_adrcyn`, the active-low TM pair and AD[1:0] recover byte-lane write strobes.
- Captures write data, runs a request/acknowledge transaction on the local register bus, and terminates the bus cycle with ready (plus read data or an error).
- Sits between the bus pins and local peripheral registers.

Parameters:
- BASE, 32'h0000_0000, base address of this target's window.
- MASK, 32'hFFFF_0000, address bits compared; hit when (addr & MASK) == BASE.
- TIMEOUT, 16, max cycles loc_req stays high without loc_ack before error; min 2.

Ports:
- clk  in  1  system clock.
- rstn  in  1  reset; synchronous, active-low.
- mst_adrcyn  in  1  low = address cycle, high = data/idle cycle.
- bus_ad_i  in  32  multiplexed bus: address (+lane code in [1:0]) in address cycle, write data after.
- bus_tm1n  in  1  transfer mode bit 1, active-low.
- bus_tm0n  in  1  transfer mode bit 0, active-low.
- slv_ad_o  out  32  read data driven to bus.
- slv_ad_oe  out  1  output enable for slv_ad_o.
- slv_rdy_o  out  1  one-cycle cycle-termination pulse.
- slv_err_o  out  1  error flag, valid only with slv_rdy_o.
- loc_req  out  1  local request, held until loc_ack or timeout.
- loc_we  out  1  1 = write, 0 = read.
- loc_be  out  4  byte enables; all ones for read.
- loc_addr  out  32  word address, {addr[31:2],2'b00}.
- loc_wdata  out  32  write data.
- loc_ack  in  1  local completion; sampled only while loc_req = 1.
- loc_rdata  in  32  read data, valid with loc_ack.

Behaviour:

Reset (rstn = 0 at posedge):
- All outputs 0; slv_ad_o = 0; state IDLE; timeout counter 0.
- Reset mid-transaction aborts it silently: no rdy, no err.

Address-cycle decode, {tm1n,tm0n}, AD = bus_ad_i[1:0]:
- 11, AD=00: read word, be=1111.
- 00: single-byte write; AD=00→be 0001, 01→0010, 10→0100, 11→1000.
- 01: multi-byte write; AD=00→be 1111, 01→0011, 11→1100, 10→illegal.
- 10: illegal; 11 with AD≠00: illegal.

FSM states: IDLE, WDATA, REQ, RESP.
- IDLE: at the posedge where mst_adrcyn = 0:
  - Address miss: stay IDLE, no response.
  - Hit + illegal encoding: go to RESP with err = 1.
  - Hit + write: latch loc_addr/loc_be, go to WDATA.
  - Hit + read: latch loc_addr/loc_be, loc_we = 0, loc_req = 1, go to REQ.
- WDATA: at the next posedge, capture bus_ad_i into loc_wdata; set loc_we = 1, loc_req = 1; go to REQ. The value of mst_adrcyn is ignored here.
- REQ: counter starts at 0 on entry and increments each cycle.
  - loc_ack = 1: drop loc_req; for reads, register loc_rdata into slv_ad_o; go to RESP (err = 0).
  - Else, counter == TIMEOUT-1: drop loc_req; go to RESP with err = 1.
  - Ack wins over timeout on the same edge.
  - loc_ack in the same cycle loc_req first appears counts.
- RESP: one cycle.
  - slv_rdy_o = 1; slv_err_o = latched err.
  - slv_ad_oe = 1 only for a successful read.
  - Next posedge: go to IDLE, clear rdy/err/oe.

Timing and ordering:
- Latency (address cycle sampled at edge N): write loc_req visible after N+1; read after N; rdy one cycle after the acking edge.
- mst_adrcyn low outside IDLE is ignored; no queueing. The master must wait for rdy.
- A new address cycle is accepted in the IDLE cycle following RESP.
- loc_addr, loc_be, loc_we and loc_wdata are stable for the whole loc_req high period.

Test Plan:
- Read hit: addr 0x0000_1230, tm=11, ack after 3 cycles with rdata 0xDEADBEEF → loc_req 3 cycles, be=1111, loc_addr=0x0000_1230; slv_ad_o=0xDEADBEEF, oe=1, rdy=1 for exactly 1 cycle.
- Byte-lane writes: tm=00, AD=00..11, data 0xA5A5A5A5 → be 0001/0010/0100/1000 and loc_addr[1:0]=00 each; tm=01, AD=00/01/11 → be 1111/0011/1100; rdy=1, err=0 each.
- Illegal encodings: tm=10; tm=01 AD=10; tm=11 AD=01 → no loc_req; rdy=1 and err=1 in the cycle after the address cycle.
- Timeout: read hit with no ack → loc_req high exactly 16 cycles, then rdy=1, err=1, oe=0. Repeat with ack on cycle 16 → err=0.
- Miss plus busy: addr 0x0001_0000 → no loc_req, no rdy. Second adrcyn pulse during REQ → ignored, single transaction completes.
- Reset in REQ: rstn=0 one cycle → all outputs 0, state IDLE; next read completes normally.
